internal_ram_arbiter: RTL and testbench
=======================================

# internal_ram_arbiter

Two-requester arbiter and sequencer for the 512x32 single-port internal RAM, which has a registered read output. It shares the RAM between the ZPU core port (port 0) and the loader/DMA port (port 1) using round-robin arbitration. It also provides byte-lane writes, which the RAM lacks natively, by running an internal read-modify-write (RMW) sequence. The block sits between the two bus masters and the RAM instance and is the only driver of the RAM's address, data and write-enable inputs.

## Interface
- ADDR_WIDTH, 9, word address width; must match the RAM.
- DATA_WIDTH, 32, word width; fixed at 32, giving 4 byte lanes.

Ports:
- clk  in  1  clock; all state updates on posedge clk.
- rst_n  in  1  synchronous active-low reset, sampled on posedge clk.
- req0, req1  in  1  request valid for port 0 / port 1.
- we0, we1  in  1  1 = write, 0 = read.
- be0, be1  in  4  byte enables for writes; bit n covers bits [8n+7:8n]. Ignored on reads.
- addr0, addr1  in  ADDR_WIDTH  word address.
- wdata0, wdata1  in  DATA_WIDTH  write data.
- gnt0, gnt1  out  1  combinational accept strobe; the request is consumed in the cycle gnt is high.
- rvalid0, rvalid1  out  1  registered; read data valid for that port.
- rdata  out  DATA_WIDTH  equals ram_dout; qualified only by rvalid0 or rvalid1.
- ram_addr  out  ADDR_WIDTH  address to the RAM.
- ram_din  out  DATA_WIDTH  write data to the RAM.
- ram_we  out  1  RAM write enable.
- ram_dout  in  DATA_WIDTH  RAM registered output; valid the cycle after ram_addr is applied.

## Operation
- **Requester rules**
  - A requester holds req, we, be, addr and wdata stable until it sees gnt.
  - Deasserting req before gnt is permitted; the request is simply withdrawn.
- **States**
  - IDLE: grants are possible.
  - RMW: second cycle of a partial write; no grants.
- **IDLE arbitration**
  - Only one requesting: that port wins.
  - Both requesting: the port other than the last-granted port wins.
  - The 1-bit last-granted pointer updates on every grant.
  - Reset value of the pointer is 1, so port 0 wins the first contention.
- **IDLE, winner's operation**, driven in the same cycle as gnt:
  - Read: ram_addr=addr, ram_we=0. The port's rvalid is set for the next cycle. Stay in IDLE.
  - Write with be=4'hF: ram_addr=addr, ram_din=wdata, ram_we=1. Stay in IDLE.
  - Write with be=4'h0: accepted with gnt, no RAM access, ram_we=0. Stay in IDLE.
  - Write with partial be:
    - Issue a read of addr (ram_we=0).
    - Latch addr, wdata and be.
    - Go to RMW.
- **RMW** (one cycle)
  - Merge per lane: lane n = latched wdata if be[n], else ram_dout.
  - Drive ram_addr=latched addr, ram_din=merged word, ram_we=1. Return to IDLE.
  - gnt0 and gnt1 are both 0 in this cycle.
- **Idle outputs**: with no grant, ram_we=0 and ram_addr holds its last value; ram_addr is a don't-care.
- **Exclusivity**: at most one of gnt0/gnt1 is high in a cycle; at most one of rvalid0/rvalid1 is high in a cycle.
- **Read-after-write ordering**
  - A read granted in the cycle after a write (full or RMW completion) returns the new data.
  - A read never shares a cycle with a RAM write, so no same-cycle collision case exists.

## Timing
- **Reads**
  - Latency: gnt in cycle T, rvalid and rdata valid in T+1.
  - Back-to-back reads run at one per cycle from either port.
- **Full-word writes**: one cycle each; back-to-back allowed.
- **Partial writes**
  - Occupy cycles T (read) and T+1 (merged write).
  - The next grant is possible in T+2.
- **Reset**
  - While rst_n=0 at the clock edge, the block enters IDLE with pointer=1 and rvalid0=rvalid1=0.
  - gnt0, gnt1 and ram_we are forced to 0 combinationally while rst_n=0.
- **Reset mid-operation**
  - Reset during RMW abandons the merged write: no write reaches the RAM and the word stays unchanged.
  - A pending rvalid is cleared.

## Test plan
- **Reset**: hold rst_n=0 for 3 cycles with req0=req1=1 → gnt0=gnt1=ram_we=rvalid0=rvalid1=0 throughout. After release, the first contended grant goes to port 0.
- **Full write then read**
  - Port 0 writes addr 0x05, data 0xDEADBEEF, be=F, then reads 0x05 in the next cycle.
  - Required: ram_we high for exactly 1 cycle; rvalid0=1 with rdata=0xDEADBEEF one cycle after the read's gnt0.
- **Partial write**
  - Start with word 0x1FF = 0x11223344. Port 1 writes 0xAABBCCDD with be=4'b0101.
  - Required: 2 busy cycles, with gnt0 low during RMW even if req0=1. A subsequent read returns 0x11BB33DD.
- **Contention**
  - req0 and req1 held high for 6 read grants to different addresses.
  - Required grant sequence: 0,1,0,1,0,1. Each rvalid appears on the correct port one cycle after its grant, with the correct data.
- **be=0 write**: port 0 writes 0xFFFFFFFF with be=0 to addr 0x10 holding 0x0 → gnt0 pulses, ram_we stays 0, and a readback gives 0x0.
- **Reset during RMW**
  - Assert rst_n=0 in the RMW cycle of a be=4'b0001 write to addr 0x20 holding 0xCAFEF00D.
  - Required: ram_we stays 0. After reset, a readback gives 0xCAFEF00D.

Source files
------------

// File: rtl/internal_ram_arbiter.sv
// Round-robin arbiter for the 512x32 internal RAM shared by the ZPU core and loader/DMA.
// Byte-lane writes are built from a two-cycle read-modify-write on the single-port RAM.
module internal_ram_arbiter #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req0,
  input  logic                    req1,
  input  logic                    we0,
  input  logic                    we1,
  input  logic [DATA_WIDTH/8-1:0] be0,
  input  logic [DATA_WIDTH/8-1:0] be1,
  input  logic [ADDR_WIDTH-1:0]   addr0,
  input  logic [ADDR_WIDTH-1:0]   addr1,
  input  logic [DATA_WIDTH-1:0]   wdata0,
  input  logic [DATA_WIDTH-1:0]   wdata1,
  output logic                    gnt0,
  output logic                    gnt1,
  output logic                    rvalid0,
  output logic                    rvalid1,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [ADDR_WIDTH-1:0]   ram_addr,
  output logic [DATA_WIDTH-1:0]   ram_din,
  output logic                    ram_we,
  input  logic [DATA_WIDTH-1:0]   ram_dout
);

  localparam int NB = DATA_WIDTH / 8;

  typedef enum logic {
    S_IDLE,
    S_RMW
  } state_e;

  state_e                state_q, state_d;
  logic                  last_q, last_d;
  logic                  rv0_q, rv0_d;
  logic                  rv1_q, rv1_d;
  logic [ADDR_WIDTH-1:0] hold_q, hold_d;
  logic [ADDR_WIDTH-1:0] rmw_addr_q, rmw_addr_d;
  logic [DATA_WIDTH-1:0] rmw_data_q, rmw_data_d;
  logic [NB-1:0]         rmw_be_q, rmw_be_d;

  logic                  idle;
  logic                  pick0;
  logic                  pick1;
  logic                  any_gnt;
  logic                  w_we;
  logic [NB-1:0]         w_be;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_full;
  logic                  w_part;
  logic [DATA_WIDTH-1:0] merged;

  // Port 1 wins when alone, or on contention when port 0 was served last.
  always_comb begin
    idle  = (state_q == S_IDLE);
    pick1 = req1 && (!req0 || !last_q);
    pick0 = req0 && !pick1;
    gnt0  = rst_n && idle && pick0;
    gnt1  = rst_n && idle && pick1;
    any_gnt = gnt0 || gnt1;
  end

  always_comb begin
    w_we    = pick1 ? we1    : we0;
    w_be    = pick1 ? be1    : be0;
    w_addr  = pick1 ? addr1  : addr0;
    w_wdata = pick1 ? wdata1 : wdata0;
    w_full  = (w_be == {NB{1'b1}});
    w_part  = !w_full && (w_be != {NB{1'b0}});
  end

  always_comb begin
    merged = ram_dout;
    for (int n = 0; n < NB; n++) begin
      if (rmw_be_q[n]) begin
        merged[8*n +: 8] = rmw_data_q[8*n +: 8];
      end
    end
  end

  always_comb begin
    ram_addr = hold_q;
    ram_din  = w_wdata;
    ram_we   = 1'b0;
    if (rst_n && state_q == S_RMW) begin
      ram_addr = rmw_addr_q;
      ram_din  = merged;
      ram_we   = 1'b1;
    end else if (any_gnt) begin
      ram_addr = w_addr;
      ram_we   = w_we && w_full;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    rv0_d      = gnt0 && !w_we;
    rv1_d      = gnt1 && !w_we;
    hold_d     = ram_addr;
    rmw_addr_d = rmw_addr_q;
    rmw_data_d = rmw_data_q;
    rmw_be_d   = rmw_be_q;
    if (state_q == S_RMW) begin
      state_d = S_IDLE;
    end else if (any_gnt) begin
      last_d = gnt1;
      if (w_we && w_part) begin
        state_d    = S_RMW;
        rmw_addr_d = w_addr;
        rmw_data_d = w_wdata;
        rmw_be_d   = w_be;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_q     <= 1'b1;
      rv0_q      <= 1'b0;
      rv1_q      <= 1'b0;
      hold_q     <= '0;
      rmw_addr_q <= '0;
      rmw_data_q <= '0;
      rmw_be_q   <= '0;
    end else begin
      state_q    <= state_d;
      last_q     <= last_d;
      rv0_q      <= rv0_d;
      rv1_q      <= rv1_d;
      hold_q     <= hold_d;
      rmw_addr_q <= rmw_addr_d;
      rmw_data_q <= rmw_data_d;
      rmw_be_q   <= rmw_be_d;
    end
  end

  assign rvalid0 = rv0_q;
  assign rvalid1 = rv1_q;
  assign rdata   = ram_dout;

endmodule

// File: tb/tb_internal_ram_arbiter.sv
// Bench for internal_ram_arbiter: RAM model, transaction-level reference model,
// directed scenarios with literal expectations and a randomized phase.
module tb_internal_ram_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req0, req1, we0, we1;
  logic [3:0]  be0, be1;
  logic [8:0]  addr0, addr1;
  logic [31:0] wdata0, wdata1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata;
  logic [8:0]  ram_addr;
  logic [31:0] ram_din;
  logic        ram_we;
  logic [31:0] ram_dout;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  internal_ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .be0(be0), .be1(be1), .addr0(addr0), .addr1(addr1),
    .wdata0(wdata0), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata(rdata), .ram_addr(ram_addr), .ram_din(ram_din),
    .ram_we(ram_we), .ram_dout(ram_dout)
  );

  // 512x32 RAM with registered read output
  logic [31:0] ram_mem [512];
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    ram_dout <= ram_mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: word memory plus pending read and pending merge
  logic [31:0] m_mem [512];
  bit          m_last = 1'b1;
  bit          m_busy = 1'b0;
  logic [8:0]  b_addr;
  logic [31:0] b_data;
  logic [3:0]  b_be;
  bit          pend_v = 1'b0;
  bit          pend_p;
  logic [31:0] pend_d;

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    logic [31:0] m;
    m = 32'h0;
    if (be[0]) m = m | 32'h0000_00FF;
    if (be[1]) m = m | 32'h0000_FF00;
    if (be[2]) m = m | 32'h00FF_0000;
    if (be[3]) m = m | 32'hFF00_0000;
    return m;
  endfunction

  task automatic model_step();
    bit          e_g0, e_g1, e_we, nv, np, p, we;
    logic [31:0] nd, d, mk;
    logic [8:0]  a;
    logic [3:0]  be;
    e_g0 = 0; e_g1 = 0; e_we = 0; nv = 0; np = 0; nd = 0;
    chk("rvalid0", {31'b0, rvalid0}, {31'b0, pend_v && !pend_p});
    chk("rvalid1", {31'b0, rvalid1}, {31'b0, pend_v && pend_p});
    if (pend_v) chk("rdata", rdata, pend_d);
    if (!rst_n) begin
      m_busy = 0;
      m_last = 1;
    end else if (m_busy) begin
      e_we = 1;
      mk = lane_mask(b_be);
      d = (b_data & mk) | (m_mem[b_addr] & ~mk);
      chk("rmw_addr", {23'b0, ram_addr}, {23'b0, b_addr});
      chk("rmw_din", ram_din, d);
      m_mem[b_addr] = d;
      m_busy = 0;
    end else if (req0 || req1) begin
      p = (req0 && req1) ? !m_last : req1;
      m_last = p;
      e_g0 = !p; e_g1 = p;
      we = p ? we1 : we0;
      be = p ? be1 : be0;
      a  = p ? addr1 : addr0;
      d  = p ? wdata1 : wdata0;
      if (!we) begin
        nv = 1; np = p; nd = m_mem[a];
        chk("rd_addr", {23'b0, ram_addr}, {23'b0, a});
      end else if (be == 4'hF) begin
        e_we = 1;
        chk("wr_addr", {23'b0, ram_addr}, {23'b0, a});
        chk("wr_din", ram_din, d);
        m_mem[a] = d;
      end else if (be != 4'h0) begin
        m_busy = 1; b_addr = a; b_data = d; b_be = be;
        chk("rmw_rd_addr", {23'b0, ram_addr}, {23'b0, a});
      end
    end
    chk("gnt0", {31'b0, gnt0}, {31'b0, e_g0});
    chk("gnt1", {31'b0, gnt1}, {31'b0, e_g1});
    chk("ram_we", {31'b0, ram_we}, {31'b0, e_we});
    pend_v = nv; pend_p = np; pend_d = nd;
  endtask

  initial begin
    forever begin
      @(negedge clk);
      #2;
      model_step();
    end
  end

  task automatic set_port(input bit p, input bit r, input bit we,
                          input logic [3:0] be, input logic [8:0] a,
                          input logic [31:0] d);
    if (!p) begin
      req0 = r; we0 = we; be0 = be; addr0 = a; wdata0 = d;
    end else begin
      req1 = r; we1 = we; be1 = be; addr1 = a; wdata1 = d;
    end
  endtask

  // Called at a negedge; returns at the negedge after the grant.
  task automatic issue(input bit p, input bit we, input logic [3:0] be,
                       input logic [8:0] a, input logic [31:0] d);
    int n;
    bit g;
    n = 0;
    set_port(p, 1'b1, we, be, a, d);
    forever begin
      #2;
      g = p ? gnt1 : gnt0;
      if (g) break;
      n++;
      if (n > 20) begin
        chk("gnt_timeout", 32'd0, 32'd1);
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    if (!p) req0 = 1'b0;
    else req1 = 1'b0;
  endtask

  task automatic read_expect(input bit p, input logic [8:0] a,
                             input logic [31:0] exp, input string name);
    issue(p, 1'b0, 4'h0, a, 32'h0);
    #2;
    chk({name, "_valid"}, {31'b0, p ? rvalid1 : rvalid0}, 32'd1);
    chk(name, rdata, exp);
    @(negedge clk);
  endtask

  initial begin
    bit          h0, h1, g0, g1, gp;
    logic [8:0]  pa0, pa1, prev_a;
    bit          prev_p;
    int          cnt0, cnt1;
    logic [31:0] r;
    for (int i = 0; i < 512; i++) begin
      ram_mem[i] = 32'h0;
      m_mem[i]   = 32'h0;
    end
    rst_n = 0;
    req0 = 0; req1 = 0; we0 = 0; we1 = 0; be0 = 0; be1 = 0;
    addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;

    for (int i = 0; i < 6; i++)
      issue(i[0], 1'b1, 4'hF, 9'h40 + 9'(i), 32'hA000_0040 + i);

    // Reset with both requesting, then contention right after release
    rst_n = 0;
    set_port(0, 1, 0, 4'h0, 9'h40, 32'h0);
    set_port(1, 1, 0, 4'h0, 9'h41, 32'h0);
    repeat (3) begin
      #2;
      chk("rst_gnt0", {31'b0, gnt0}, 32'd0);
      chk("rst_gnt1", {31'b0, gnt1}, 32'd0);
      chk("rst_we", {31'b0, ram_we}, 32'd0);
      chk("rst_rv", {30'b0, rvalid1, rvalid0}, 32'd0);
      @(negedge clk);
    end
    rst_n = 1;
    pa0 = 9'h40; pa1 = 9'h41; cnt0 = 0; cnt1 = 0;
    prev_a = 0; prev_p = 0;
    for (int k = 0; k < 6; k++) begin
      #2;
      if (k > 0) begin
        chk("cont_rv", {30'b0, rvalid1, rvalid0},
            prev_p ? 32'd2 : 32'd1);
        chk("cont_rdata", rdata, 32'hA000_0000 + 32'(prev_a));
      end
      gp = gnt1;
      chk("cont_gnt", {30'b0, gnt1, gnt0}, (k % 2 == 1) ? 32'd2 : 32'd1);
      prev_p = gp;
      prev_a = gp ? pa1 : pa0;
      @(negedge clk);
      if (!gp) begin
        cnt0++; pa0 = pa0 + 9'd2; addr0 = pa0;
        if (cnt0 == 3) req0 = 0;
      end else begin
        cnt1++; pa1 = pa1 + 9'd2; addr1 = pa1;
        if (cnt1 == 3) req1 = 0;
      end
    end
    #2;
    chk("cont_rv_last", {30'b0, rvalid1, rvalid0}, 32'd2);
    chk("cont_rdata_last", rdata, 32'hA000_0045);
    @(negedge clk);

    // Full write immediately followed by read of the same word
    issue(0, 1'b1, 4'hF, 9'h05, 32'hDEAD_BEEF);
    read_expect(0, 9'h05, 32'hDEAD_BEEF, "full_rd");

    // Partial write from port 1 while port 0 waits to read
    issue(0, 1'b1, 4'hF, 9'h1FF, 32'h1122_3344);
    set_port(1, 1, 1, 4'b0101, 9'h1FF, 32'hAABB_CCDD);
    set_port(0, 1, 0, 4'h0, 9'h1FF, 32'h0);
    #2;
    chk("pw_gnt1", {31'b0, gnt1}, 32'd1);
    @(negedge clk);
    req1 = 0;
    #2;
    chk("pw_rmw_gnt0", {31'b0, gnt0}, 32'd0);
    chk("pw_rmw_we", {31'b0, ram_we}, 32'd1);
    @(negedge clk);
    #2;
    chk("pw_gnt0_after", {31'b0, gnt0}, 32'd1);
    @(negedge clk);
    req0 = 0;
    #2;
    chk("pw_rv0", {31'b0, rvalid0}, 32'd1);
    chk("pw_rdata", rdata, 32'h11BB_33DD);
    @(negedge clk);

    // be=0 write leaves memory untouched
    issue(0, 1'b1, 4'hF, 9'h10, 32'h0);
    issue(0, 1'b1, 4'h0, 9'h10, 32'hFFFF_FFFF);
    read_expect(1, 9'h10, 32'h0, "be0_rd");

    // Reset landing on the RMW cycle drops the merged write
    issue(1, 1'b1, 4'hF, 9'h20, 32'hCAFE_F00D);
    issue(0, 1'b1, 4'b0001, 9'h20, 32'h1234_5678);
    rst_n = 0;
    #2;
    chk("rstrmw_we", {31'b0, ram_we}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    read_expect(0, 9'h20, 32'hCAFE_F00D, "rstrmw_rd");

    // Randomized traffic with hold-until-grant and occasional withdrawal
    h0 = 0; h1 = 0; g0 = 0; g1 = 0;
    repeat (3000) begin
      if (h0 && g0) h0 = 0;
      if (h1 && g1) h1 = 0;
      if (h0 && $urandom_range(15) == 0) h0 = 0;
      if (h1 && $urandom_range(15) == 0) h1 = 0;
      if (!h0 && $urandom_range(1) == 1) begin
        h0 = 1;
        r = $urandom;
        set_port(0, 1, r[0], r[2:1] == 0 ? 4'hF : r[2:1] == 1 ? 4'h0 : r[7:4],
                 9'($urandom_range(15)), $urandom);
      end
      if (!h1 && $urandom_range(1) == 1) begin
        h1 = 1;
        r = $urandom;
        set_port(1, 1, r[0], r[2:1] == 0 ? 4'hF : r[2:1] == 1 ? 4'h0 : r[7:4],
                 9'($urandom_range(15)), $urandom);
      end
      req0 = h0;
      req1 = h1;
      #2;
      g0 = gnt0;
      g1 = gnt1;
      @(negedge clk);
    end
    req0 = 0;
    req1 = 0;
    repeat (4) @(negedge clk);
    #3;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
